// File: rtl/usb_pkg.sv
// Shared definitions for the usb command/readback path: scheduler state encoding
// and the packet-type codes carried on send_btype/read_btype.
// Imported by usb_sched and usb_rr_arb; the BTYPE_* codes are also used by the usb tx/cs blocks.
package usb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT_TX = 3'd2,
        ST_WAIT_RX = 3'd3,
        ST_ACK     = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAIL    = 3'd6
    } sched_state_t;

    localparam logic [3:0] BTYPE_NONE  = 4'h0;
    localparam logic [3:0] BTYPE_CMD   = 4'h1;
    localparam logic [3:0] BTYPE_READ  = 4'h2;
    localparam logic [3:0] BTYPE_WRITE = 4'h3;
    localparam logic [3:0] BTYPE_STAT  = 4'h5;

endpackage

// File: rtl/usb_rr_arb.sv
// Round-robin picker: first set req bit at or after ptr, wrapping, as one-hot gnt plus index.
// Latency: purely combinational, no state (the pointer is owned by the caller).
// Backpressure: none; any=0 when no request is pending.
//  req [NREQ]  request levels      ptr [IDW]  highest-priority index
//  gnt [NREQ]  one-hot winner      id  [IDW]  winner index      any  a winner exists
module usb_rr_arb
    import usb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  id,
    output logic            any
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest requester at/after ptr wins.
    always_comb begin
        gnt = '0;
        id  = '0;
        any = 1'b0;
        sum = '0;
        idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sum = {1'b0, ptr} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(NREQ)) begin
                sum = sum - (IDW+1)'(NREQ);
            end
            idx = sum[IDW-1:0];
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
                id       = idx;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/usb_sched.sv
// Round-robin scheduler sharing the usb command/readback channel among NREQ requesters,
// Latency: req -> fs_send 2 cycles; rsp_valid one cycle after the fd_read handshake closes.
// Backpressure: requesters hold req until rsp_valid; usb side uses fs_send/fd_send and four-phase fs_read/fd_read.
//  clk, rst                  sync active-high reset
//  req/req_btype/req_cmd/req_rinit   per-requester request level and payload slices
//  rsp_valid/rsp_err/rsp_stat        one-hot completion pulse, error flag, captured cache_stat
//  busy                              state != IDLE
//  fs_send/send_btype/cache_cmd/fd_send          command channel to/from usb
//  fs_read/read_btype/read_ram_init/fd_read/cache_stat   readback channel to/from usb
module usb_sched
    import usb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int TMO   = 4096,
    parameter int RETRY = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [4*NREQ-1:0]  req_btype,
    input  logic [32*NREQ-1:0] req_cmd,
    input  logic [12*NREQ-1:0] req_rinit,
    output logic [NREQ-1:0]    rsp_valid,
    output logic               rsp_err,
    output logic [31:0]        rsp_stat,
    output logic               busy,
    output logic               fs_send,
    output logic [3:0]         send_btype,
    output logic [31:0]        cache_cmd,
    input  logic               fd_send,
    input  logic               fs_read,
    input  logic [3:0]         read_btype,
    output logic [11:0]        read_ram_init,
    output logic               fd_read,
    input  logic [31:0]        cache_stat
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = $clog2(TMO + 1);
    localparam int RW  = (RETRY > 0) ? $clog2(RETRY + 1) : 1;

    sched_state_t   state;
    logic [NREQ-1:0] gnt_q;
    logic [IDW-1:0]  id_q;
    logic [3:0]      btype_q;
    logic [31:0]     cmd_q;
    logic [11:0]     rinit_q;
    logic [31:0]     stat_q;
    logic [IDW-1:0]  rr_q;
    logic [RW-1:0]   retry_q;
    logic [TW-1:0]   timer_q;
    logic            tx_seen_q;   // fd_send already observed high in this send
    logic            stray_q;     // current ACK is for a dropped wrong-type packet

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;
    logic            arb_any;
    logic [3:0]      sel_btype;
    logic [31:0]     sel_cmd;
    logic [11:0]     sel_rinit;

    usb_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req (req),
        .ptr (rr_q),
        .gnt (arb_gnt),
        .id  (arb_id),
        .any (arb_any)
    );

    always_comb begin
        sel_btype = '0;
        sel_cmd   = '0;
        sel_rinit = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_gnt[i]) begin
                sel_btype = req_btype[4*i +: 4];
                sel_cmd   = req_cmd[32*i +: 32];
                sel_rinit = req_rinit[12*i +: 12];
            end
        end
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            gnt_q         <= '0;
            id_q          <= '0;
            btype_q       <= '0;
            cmd_q         <= '0;
            rinit_q       <= '0;
            stat_q        <= '0;
            rr_q          <= '0;
            retry_q       <= '0;
            timer_q       <= '0;
            tx_seen_q     <= 1'b0;
            stray_q       <= 1'b0;
            rsp_valid     <= '0;
            rsp_err       <= 1'b0;
            rsp_stat      <= '0;
            fs_send       <= 1'b0;
            send_btype    <= '0;
            cache_cmd     <= '0;
            read_ram_init <= '0;
            fd_read       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_any) begin
                        gnt_q   <= arb_gnt;
                        id_q    <= arb_id;
                        btype_q <= sel_btype;
                        cmd_q   <= sel_cmd;
                        rinit_q <= sel_rinit;
                        retry_q <= '0;
                        state   <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    fs_send    <= 1'b1;
                    send_btype <= btype_q;
                    cache_cmd  <= cmd_q;
                    tx_seen_q  <= 1'b0;
                    state      <= ST_WAIT_TX;
                end

                // Two phases: wait for fd_send high, then for it to fall again,
                // so a usb block that holds fd_send as a level is not double-counted.
                ST_WAIT_TX: begin
                    if (!tx_seen_q) begin
                        if (fd_send) begin
                            fs_send   <= 1'b0;
                            timer_q   <= '0;
                            tx_seen_q <= 1'b1;
                        end
                    end else if (!fd_send) begin
                        read_ram_init <= rinit_q;
                        state         <= ST_WAIT_RX;
                    end
                end

                // fs_read is tested before the timeout so a reply landing on the
                // last timer cycle still counts as success.
                ST_WAIT_RX: begin
                    if (fs_read) begin
                        fd_read <= 1'b1;
                        stray_q <= (read_btype != btype_q);
                        if (read_btype == btype_q) begin
                            stat_q <= cache_stat;
                        end
                        state <= ST_ACK;
                    end else if (timer_q == TW'(TMO - 1)) begin
                        if (retry_q < RW'(RETRY)) begin
                            retry_q <= retry_q + RW'(1);
                            state   <= ST_SEND;
                        end else begin
                            rsp_valid     <= gnt_q;
                            rsp_err       <= 1'b1;
                            rsp_stat      <= '0;
                            read_ram_init <= '0;
                            state         <= ST_FAIL;
                        end
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end

                // Stray packets return to WAIT_RX with the timer untouched.
                ST_ACK: begin
                    if (!fs_read) begin
                        fd_read <= 1'b0;
                        if (stray_q) begin
                            state <= ST_WAIT_RX;
                        end else begin
                            rsp_valid     <= gnt_q;
                            rsp_err       <= 1'b0;
                            rsp_stat      <= stat_q;
                            read_ram_init <= '0;
                            state         <= ST_DONE;
                        end
                    end
                end

                ST_DONE, ST_FAIL: begin
                    rsp_valid  <= '0;
                    rsp_err    <= 1'b0;
                    rsp_stat   <= '0;
                    send_btype <= '0;
                    cache_cmd  <= '0;
                    retry_q    <= '0;
                    rr_q       <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + IDW'(1);
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_sched.sv
// Bench for usb_sched: directed scenarios plus randomized round-robin traffic.
// A behavioural usb responder answers sends; expectations come from a simple queue-free model.
// Outputs are sampled on the falling clock edge; inputs change there too.
module tb_usb_sched;

    localparam int NREQ  = 4;
    localparam int TMO   = 64;
    localparam int RETRY = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [4*NREQ-1:0]  req_btype;
    logic [32*NREQ-1:0] req_cmd;
    logic [12*NREQ-1:0] req_rinit;
    logic [NREQ-1:0]    rsp_valid;
    logic               rsp_err;
    logic [31:0]        rsp_stat;
    logic               busy;
    logic               fs_send;
    logic [3:0]         send_btype;
    logic [31:0]        cache_cmd;
    logic               fd_send;
    logic               fs_read;
    logic [3:0]         read_btype;
    logic [11:0]        read_ram_init;
    logic               fd_read;
    logic [31:0]        cache_stat;

    usb_sched #(.NREQ(NREQ), .TMO(TMO), .RETRY(RETRY)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_btype     (req_btype),
        .req_cmd       (req_cmd),
        .req_rinit     (req_rinit),
        .rsp_valid     (rsp_valid),
        .rsp_err       (rsp_err),
        .rsp_stat      (rsp_stat),
        .busy          (busy),
        .fs_send       (fs_send),
        .send_btype    (send_btype),
        .cache_cmd     (cache_cmd),
        .fd_send       (fd_send),
        .fs_read       (fs_read),
        .read_btype    (read_btype),
        .read_ram_init (read_ram_init),
        .fd_read       (fd_read),
        .cache_stat    (cache_stat)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // per-requester payloads, packed onto the DUT buses
    logic [3:0]  bt [NREQ];
    logic [31:0] cm [NREQ];
    logic [11:0] ri [NREQ];

    always_comb begin
        req_btype = '0;
        req_cmd   = '0;
        req_rinit = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_btype[4*i +: 4]   = bt[i];
            req_cmd[32*i +: 32]   = cm[i];
            req_rinit[12*i +: 12] = ri[i];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // usb responder configuration and observations
    int          tx_dly = 10;
    int          rx_dly = 50;
    bit          no_reply = 1'b0;
    bit          stray_en = 1'b0;
    logic [31:0] reply_stat = '0;
    int          n_send = 0;
    int          n_ack = 0;
    int          send_cyc[$];
    logic [31:0] seen_cmd = '0;
    logic [3:0]  seen_btype = '0;
    logic [11:0] seen_rinit = '0;

    task automatic usb_pkt(input logic [3:0] b, input logic [31:0] s, output bit ok);
        int g;
        ok         = 1'b1;
        fs_read    = 1'b1;
        read_btype = b;
        cache_stat = s;
        seen_rinit = read_ram_init;
        g = 0;
        while (ok && !fd_read) begin
            @(negedge clk);
            g++;
            if (rst || g > 200) ok = 1'b0;
        end
        fs_read    = 1'b0;
        read_btype = '0;
        cache_stat = '0;
        g = 0;
        while (ok && fd_read) begin
            @(negedge clk);
            g++;
            if (rst || g > 200) ok = 1'b0;
        end
        if (ok) n_ack++;
    endtask

    initial begin : usb_model
        bit ok;
        int g;
        fd_send    = 1'b0;
        fs_read    = 1'b0;
        read_btype = '0;
        cache_stat = '0;
        forever begin
            @(negedge clk);
            if (!rst && fs_send) begin
                n_send++;
                send_cyc.push_back(cyc);
                seen_cmd   = cache_cmd;
                seen_btype = send_btype;
                ok = 1'b1;
                for (int i = 0; i < tx_dly; i++) begin
                    @(negedge clk);
                    if (rst) begin
                        ok = 1'b0;
                        break;
                    end
                end
                if (ok) begin
                    fd_send = 1'b1;
                    g = 0;
                    while (ok && fs_send) begin
                        @(negedge clk);
                        g++;
                        if (rst || g > 200) ok = 1'b0;
                    end
                    fd_send = 1'b0;
                end
                if (ok && !no_reply) begin
                    if (stray_en) begin
                        repeat (rx_dly) @(negedge clk);
                        usb_pkt(4'h5, 32'hDEAD_BEEF, ok);
                        repeat (3) @(negedge clk);
                    end
                    if (ok) begin
                        repeat (rx_dly) @(negedge clk);
                        usb_pkt(seen_btype, reply_stat, ok);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: observed no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    logic [NREQ-1:0] r_valid;
    logic            r_err;
    logic [31:0]     r_stat;

    task automatic wait_rsp(input string tag, input int lim);
        bit got;
        got = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (rsp_valid != '0) begin
                got = 1'b1;
                break;
            end
        end
        r_valid = rsp_valid;
        r_err   = rsp_err;
        r_stat  = rsp_stat;
        check(tag, 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : main
        int          ptr;
        int          expw;
        int          d;
        bit          got;
        logic [NREQ-1:0] pend;
        logic [NREQ-1:0] nbits;

        rst = 1'b1;
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            bt[i] = '0;
            cm[i] = '0;
            ri[i] = '0;
        end
        repeat (3) @(negedge clk);

        // reset state
        check("rst_fs_send", 64'(fs_send), 64'd0);
        check("rst_fd_read", 64'(fd_read), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_rsp_stat", 64'(rsp_stat), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_ram_init", 64'(read_ram_init), 64'd0);
        check("rst_cache_cmd", 64'(cache_cmd), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single transaction, latency and payload routing
        bt[0] = 4'h2; cm[0] = 32'hA5A5_0001; ri[0] = 12'h100;
        tx_dly = 10; rx_dly = 50; reply_stat = 32'h0000_00FF;
        n_send = 0; n_ack = 0;
        req = 4'b0001;
        @(negedge clk);
        check("lat_fs_send_c1", 64'(fs_send), 64'd0);
        @(negedge clk);
        check("lat_fs_send_c2", 64'(fs_send), 64'd1);
        check("lat_busy", 64'(busy), 64'd1);
        wait_rsp("t1_rsp_seen", 400);
        check("t1_rsp_valid", 64'(r_valid), 64'h1);
        check("t1_rsp_stat", 64'(r_stat), 64'hFF);
        check("t1_rsp_err", 64'(r_err), 64'd0);
        check("t1_rinit", 64'(seen_rinit), 64'h100);
        check("t1_cmd", 64'(seen_cmd), 64'hA5A5_0001);
        check("t1_btype", 64'(seen_btype), 64'h2);
        check("t1_nsend", 64'(n_send), 64'd1);
        req = '0;
        @(negedge clk);
        check("t1_pulse_len", 64'(rsp_valid), 64'd0);
        check("t1_idle_busy", 64'(busy), 64'd0);

        // all requesters held: strict rotation
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            bt[i] = 4'($urandom_range(1, 15));
            cm[i] = $urandom;
            ri[i] = 12'($urandom);
        end
        tx_dly = 3; rx_dly = 5; n_send = 0;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            reply_stat = $urandom;
            wait_rsp("rr_rsp_seen", 300);
            check("rr_order", 64'(r_valid), 64'(1 << (k % NREQ)));
            check("rr_err", 64'(r_err), 64'd0);
            check("rr_cmd", 64'(seen_cmd), 64'(cm[k % NREQ]));
            if (k == 4) req = '0;
        end
        repeat (5) @(negedge clk);
        check("rr_nsend", 64'(n_send), 64'd5);
        check("rr_busy_end", 64'(busy), 64'd0);

        // no reply at all: 1 + RETRY sends, then error completion
        do_reset();
        bt[0] = 4'h2; cm[0] = 32'h1111_2222; ri[0] = 12'h0AB;
        tx_dly = 10; no_reply = 1'b1; n_send = 0;
        send_cyc.delete();
        req = 4'b0001;
        wait_rsp("tmo_rsp_seen", 1500);
        check("tmo_rsp_valid", 64'(r_valid), 64'h1);
        check("tmo_rsp_err", 64'(r_err), 64'd1);
        check("tmo_rsp_stat", 64'(r_stat), 64'd0);
        check("tmo_nsend", 64'(n_send), 64'(RETRY + 1));
        for (int i = 1; i < send_cyc.size(); i++) begin
            d = send_cyc[i] - send_cyc[i-1];
            check("tmo_gap_in_window", 64'(d >= TMO && d <= TMO + tx_dly + 8), 64'd1);
        end
        req = '0;
        repeat (100) @(negedge clk);
        check("tmo_no_extra_send", 64'(n_send), 64'(RETRY + 1));
        no_reply = 1'b0;

        // stray packet of the wrong type, then the real reply
        do_reset();
        bt[0] = 4'h2; cm[0] = 32'h3333_4444; ri[0] = 12'h200;
        tx_dly = 4; rx_dly = 15; stray_en = 1'b1;
        reply_stat = 32'h1234_5678; n_send = 0; n_ack = 0;
        req = 4'b0001;
        wait_rsp("stray_rsp_seen", 600);
        check("stray_rsp_stat", 64'(r_stat), 64'h1234_5678);
        check("stray_rsp_err", 64'(r_err), 64'd0);
        check("stray_nack", 64'(n_ack), 64'd2);
        check("stray_nsend", 64'(n_send), 64'd1);
        req = '0;
        stray_en = 1'b0;

        // reply lands on the last timer cycle: success, no re-send
        do_reset();
        tx_dly = 6; rx_dly = TMO; reply_stat = 32'hCAFE_0001;
        n_send = 0;
        req = 4'b0001;
        wait_rsp("edge_rsp_seen", 600);
        check("edge_rsp_err", 64'(r_err), 64'd0);
        check("edge_rsp_stat", 64'(r_stat), 64'hCAFE_0001);
        check("edge_nsend", 64'(n_send), 64'd1);
        req = '0;

        // reset while waiting for fd_send
        do_reset();
        tx_dly = 30; rx_dly = 8; reply_stat = 32'h0BAD_F00D;
        req = 4'b0001;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fs_send) begin
                got = 1'b1;
                break;
            end
        end
        check("rstmid_fs_send_seen", 64'(got), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_fs_send", 64'(fs_send), 64'd0);
        check("rstmid_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tx_dly = 5;
        n_send = 0;
        wait_rsp("rstmid_rsp_seen", 600);
        check("rstmid_rsp_valid", 64'(r_valid), 64'h1);
        check("rstmid_rsp_stat", 64'(r_stat), 64'h0BAD_F00D);
        check("rstmid_nsend", 64'(n_send), 64'd1);
        req = '0;

        // randomized traffic against a round-robin reference
        do_reset();
        ptr  = 0;
        pend = '0;
        for (int t = 0; t < 24; t++) begin
            nbits = 4'($urandom_range(0, 15)) & ~pend;
            if ((pend | nbits) == '0) nbits = 4'(1 << $urandom_range(0, NREQ - 1));
            for (int i = 0; i < NREQ; i++) begin
                if (nbits[i]) begin
                    bt[i] = 4'($urandom_range(1, 15));
                    cm[i] = $urandom;
                    ri[i] = 12'($urandom);
                end
            end
            pend       = pend | nbits;
            reply_stat = $urandom;
            tx_dly     = $urandom_range(1, 8);
            rx_dly     = $urandom_range(1, 40);
            req        = pend;
            expw = -1;
            for (int k = 0; k < NREQ; k++) begin
                if (expw < 0 && pend[(ptr + k) % NREQ]) expw = (ptr + k) % NREQ;
            end
            wait_rsp("rnd_rsp_seen", 400);
            check("rnd_winner", 64'(r_valid), 64'(1 << expw));
            check("rnd_err", 64'(r_err), 64'd0);
            check("rnd_stat", 64'(r_stat), 64'(reply_stat));
            check("rnd_cmd", 64'(seen_cmd), 64'(cm[expw]));
            check("rnd_btype", 64'(seen_btype), 64'(bt[expw]));
            check("rnd_rinit", 64'(seen_rinit), 64'(ri[expw]));
            pend[expw] = 1'b0;
            req = pend;
            ptr = (expw + 1) % NREQ;
        end
        req = '0;
        repeat (10) @(negedge clk);
        check("final_busy", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
